// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit shift on
// device clock falling edges, ACK capture and bus-idle wait, with a timeout guard.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       write,
   input  logic [7:0] writedata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout_err,
   inout  logic       ps2_clk,
   inout  logic       ps2_data
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t        state, state_next;
   logic [1:0]    clk_sync, data_sync;
   logic          clk_filt, data_filt, clk_filt_d;
   logic [FW-1:0] clk_cnt, data_cnt;
   logic [9:0]    frame;
   logic [3:0]    bit_idx;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] to_cnt;
   logic          fall, counting, to_hit;
   logic          accept, finish, expire;
   logic          clk_oe, data_oe;
   logic [10:0]   seq;

   // Input conditioning: a filtered line only changes after FILTER_LEN equal samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         clk_filt   <= 1'b1;
         data_filt  <= 1'b1;
         clk_filt_d <= 1'b1;
         clk_cnt    <= '0;
         data_cnt   <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk};
         data_sync  <= {data_sync[0], ps2_data};
         clk_filt_d <= clk_filt;
         if (clk_sync[1] == clk_filt) begin
            clk_cnt <= '0;
         end else if (clk_cnt == FILT_LAST) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= '0;
         end else begin
            clk_cnt <= clk_cnt + FW'(1);
         end
         if (data_sync[1] == data_filt) begin
            data_cnt <= '0;
         end else if (data_cnt == FILT_LAST) begin
            data_filt <= data_sync[1];
            data_cnt  <= '0;
         end else begin
            data_cnt <= data_cnt + FW'(1);
         end
      end
   end

   assign fall     = clk_filt_d & ~clk_filt;
   assign counting = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
   assign to_hit   = (to_cnt == TO_LAST);
   // Index 0 is the start bit; index k carries frame bit k-1 after falling edge k.
   assign seq      = {frame, 1'b0};

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      expire     = 1'b0;
      clk_oe     = 1'b0;
      data_oe    = 1'b0;
      case (state)
         S_IDLE: begin
            if (write && !done) begin
               accept     = 1'b1;
               state_next = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            clk_oe = 1'b1;
            if (inh_cnt == INH_LAST) state_next = S_RTS;
         end
         S_RTS: begin
            clk_oe     = 1'b1;
            data_oe    = 1'b1;
            state_next = S_SEND;
         end
         S_SEND: begin
            data_oe = ~seq[bit_idx];
            if (fall && bit_idx == 4'd9) state_next = S_ACK;
         end
         S_ACK: begin
            if (fall) state_next = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (clk_filt && data_filt) begin
               finish     = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
      if (counting && !fall && to_hit && !finish) begin
         expire     = 1'b1;
         finish     = 1'b1;
         state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         frame       <= '0;
         bit_idx     <= '0;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         done        <= 1'b0;
         ack_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_next;
         done  <= finish;
         if (accept) begin
            frame       <= {1'b1, ~^writedata, writedata};
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
         end
         if (expire) timeout_err <= 1'b1;
         if (state == S_ACK && fall) ack_err <= data_filt;
         inh_cnt <= (state == S_INHIBIT) ? inh_cnt + IW'(1) : '0;
         if (state == S_RTS) begin
            bit_idx <= '0;
         end else if (state == S_SEND && fall) begin
            bit_idx <= bit_idx + 4'd1;
         end
         if (state == S_RTS || fall || !counting) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + TW'(1);
         end
      end
   end

   assign busy     = (state != S_IDLE);
   assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
   assign ps2_data = data_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and every received frame and status flag is compared against expected values.
module tb_ps2_host_tx;

   logic       clk;
   logic       reset_n;
   logic       write;
   logic [7:0] writedata;
   logic       busy, done, ack_err, timeout_err;
   logic       dev_clk_low, dev_data_low;
   wire        ps2_clk, ps2_data;

   int checks = 0;
   int errors = 0;
   int done_pulses = 0;

   assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_data);

   ps2_host_tx #(
      .INHIBIT_CYCLES(20),
      .TIMEOUT_CYCLES(2000),
      .FILTER_LEN(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .write(write),
      .writedata(writedata),
      .busy(busy),
      .done(done),
      .ack_err(ack_err),
      .timeout_err(timeout_err),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_pulses++;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         glitch;
      logic [9:0] frame;
      bit         ack_err;
   } vec_t;

   // Expected frame straight from the protocol rules: data LSB first, odd parity, stop 1.
   function automatic logic [9:0] ref_frame(input logic [7:0] b);
      return {1'b1, ($countones(b) % 2 == 0), b};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Entered on the first inhibit cycle; leaves on the first SEND cycle.
   task automatic expect_rts(input int poke_at, output int inh);
      inh = 0;
      while (ps2_clk === 1'b0 && ps2_data === 1'b1 && inh < 200) begin
         if (inh == poke_at) begin
            writedata = 8'h00;
            write     = 1'b1;
         end
         cyc(1);
         write = 1'b0;
         inh++;
      end
      check("rts_both_low", {ps2_clk, ps2_data}, 2'b00);
      cyc(1);
      check("send_start_bit", {ps2_clk, ps2_data}, 2'b10);
   endtask

   task automatic dev_clock(input bit ack, input bit glitch, input int stop_after,
                            input int poke_k, output logic [9:0] got);
      got = '0;
      cyc(40);
      for (int k = 1; k <= 10; k++) begin
         dev_clk_low = 1'b1;
         if (k == poke_k) begin
            writedata = 8'h00;
            write     = 1'b1;
            cyc(1);
            write     = 1'b0;
            cyc(19);
         end else begin
            cyc(20);
         end
         if (k == stop_after) return;
         cyc(20);
         got[k-1]    = ps2_data;
         dev_clk_low = 1'b0;
         if (glitch) begin
            cyc(10);
            dev_clk_low = 1'b1;
            cyc(2);
            dev_clk_low = 1'b0;
            cyc(28);
         end else begin
            cyc(40);
         end
      end
      dev_data_low = ack;
      cyc(20);
      dev_clk_low = 1'b1;
      cyc(40);
      dev_clk_low = 1'b0;
   endtask

   task automatic run_vector(input logic [7:0] b, input bit ack, input bit glitch,
                             input logic [9:0] exp_fr, input bit exp_ae,
                             input int poke_inh, input int poke_k, input bit poke_done);
      int inh, n, d0;
      logic [9:0] got;
      d0        = done_pulses;
      writedata = b;
      write     = 1'b1;
      cyc(1);
      write     = 1'b0;
      check("busy_after_write", busy, 1);
      check("errs_cleared", {ack_err, timeout_err}, 0);
      expect_rts(poke_inh, inh);
      check("inhibit_len", inh, 20);
      dev_clock(ack, glitch, 11, poke_k, got);
      check("frame", got, exp_fr);
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         cyc(1);
         n++;
         if (n == 10) dev_data_low = 1'b0;
      end
      dev_data_low = 1'b0;
      check("done_seen", done, 1);
      check("busy_at_done", busy, 0);
      check("ack_err", ack_err, exp_ae);
      check("timeout_err", timeout_err, 0);
      check("lines_idle", {ps2_clk, ps2_data}, 2'b11);
      if (poke_done) begin
         writedata = 8'h77;
         write     = 1'b1;
      end
      cyc(1);
      write = 1'b0;
      check("done_width", done, 0);
      check("busy_after_done", busy, 0);
      if (poke_done) begin
         cyc(1);
         check("write_at_done_ignored", busy, 0);
      end
      check("done_count", done_pulses - d0, 1);
   endtask

   initial begin
      vec_t vecs[7];
      int inh, n, d0;
      logic [9:0] got;
      logic [7:0] rb;
      bit rack;

      vecs[0] = '{data: 8'hF4, ack: 1'b1, glitch: 1'b0, frame: 10'h2F4, ack_err: 1'b0};
      vecs[1] = '{data: 8'hFF, ack: 1'b1, glitch: 1'b0, frame: 10'h3FF, ack_err: 1'b0};
      vecs[2] = '{data: 8'h00, ack: 1'b1, glitch: 1'b0, frame: 10'h300, ack_err: 1'b0};
      vecs[3] = '{data: 8'h01, ack: 1'b1, glitch: 1'b0, frame: 10'h201, ack_err: 1'b0};
      vecs[4] = '{data: 8'hA5, ack: 1'b0, glitch: 1'b0, frame: 10'h3A5, ack_err: 1'b1};
      vecs[5] = '{data: 8'hED, ack: 1'b1, glitch: 1'b0, frame: 10'h3ED, ack_err: 1'b0};
      vecs[6] = '{data: 8'h3C, ack: 1'b1, glitch: 1'b1, frame: 10'h33C, ack_err: 1'b0};

      clk          = 1'b0;
      reset_n      = 1'b0;
      write        = 1'b0;
      writedata    = 8'h00;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      cyc(3);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_errs", {ack_err, timeout_err}, 0);
      check("reset_lines", {ps2_clk, ps2_data}, 2'b11);
      reset_n = 1'b1;
      cyc(10);

      for (int i = 0; i < 7; i++)
         run_vector(vecs[i].data, vecs[i].ack, vecs[i].glitch, vecs[i].frame,
                    vecs[i].ack_err, -1, -1, 1'b0);

      // Silent device: timeout must fire exactly TIMEOUT_CYCLES after SEND entry.
      d0        = done_pulses;
      writedata = 8'h55;
      write     = 1'b1;
      cyc(1);
      write     = 1'b0;
      expect_rts(-1, inh);
      check("to_inhibit_len", inh, 20);
      n = 0;
      while (done !== 1'b1 && n < 2100) begin
         cyc(1);
         n++;
      end
      check("timeout_latency", n, 2000);
      check("timeout_busy", busy, 0);
      check("timeout_flag", timeout_err, 1);
      check("timeout_ack_err", ack_err, 0);
      check("timeout_lines", {ps2_clk, ps2_data}, 2'b11);
      cyc(1);
      check("timeout_done_count", done_pulses - d0, 1);

      // Writes during INHIBIT, during SEND and in the done cycle are all ignored.
      run_vector(8'hF4, 1'b1, 1'b0, ref_frame(8'hF4), 1'b0, 5, 3, 1'b1);

      // Reset mid-frame releases the pins asynchronously with no done pulse.
      writedata = 8'h12;
      write     = 1'b1;
      cyc(1);
      write     = 1'b0;
      expect_rts(-1, inh);
      dev_clock(1'b1, 1'b0, 4, -1, got);
      check("pre_reset_data_driven", ps2_data, 0);
      d0          = done_pulses;
      dev_clk_low = 1'b0;
      reset_n     = 1'b0;
      #1;
      check("async_reset_lines", {ps2_clk, ps2_data}, 2'b11);
      check("async_reset_busy", busy, 0);
      cyc(3);
      reset_n = 1'b1;
      cyc(10);
      check("reset_no_done", done_pulses - d0, 0);
      run_vector(8'hAA, 1'b1, 1'b0, 10'h3AA, 1'b0, -1, -1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         rb   = 8'($urandom_range(0, 255));
         rack = ($urandom_range(0, 3) != 0);
         run_vector(rb, rack, 1'b0, ref_frame(rb), !rack, -1, -1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter that sends one command byte to a keyboard or mouse, for example 0xFF reset, 0xF4 enable reporting, or 0xED LEDs.
- It is the transmit-side companion of the PS/2 receiver and shares the same open-drain ps2_clk/ps2_data pins.
- Runs the full inhibit, request-to-send, bit-shift and ACK sequence, then reports completion and errors.
- The receiver ignores traffic while busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles that ps2_clk is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, max clk cycles between device clock falling edges, or while waiting for bus idle (15 ms at 50 MHz).
FILTER_LEN, 8, consecutive identical synchronized samples needed to change a filtered line value.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
write  input  1  command strobe; sampled on rising clk
writedata  input  8  command byte
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end (success or error)
ack_err  output  1  device did not ACK the last transaction
timeout_err  output  1  last transaction timed out
ps2_clk  inout  1  open-drain PS/2 clock; driven 0 or Z only
ps2_data  inout  1  open-drain PS/2 data; driven 0 or Z only

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; both lines Z.
  - busy, done, ack_err, timeout_err = 0.
  - Filtered clk/data = 1; counters = 0.
- Inputs: 2-flop synchronizer, then FILTER_LEN-sample filter. Falling edge = filtered clk goes 1 to 0 between consecutive cycles.
- Frame register, 10 bits: {stop=1, parity, data[7:0]}, LSB sent first. Parity is odd: ~^writedata.
- IDLE:
  - Lines Z; busy=0.
  - write=1 latches writedata, clears ack_err and timeout_err, goes to INHIBIT. busy=1 from the next cycle.
- INHIBIT:
  - ps2_clk driven 0 for exactly INHIBIT_CYCLES cycles; ps2_data Z. Then go to RTS.
- RTS:
  - ps2_clk and ps2_data both driven 0 for one cycle (start bit).
  - Then release ps2_clk, clear the timeout counter and bit index, go to SEND.
- SEND:
  - ps2_data is driven 0 while the current bit is 0, Z while it is 1. The start bit is 0 until the 1st falling edge.
  - Falling edge k (k=1..10) presents frame bit k-1.
  - After the 10th falling edge the stop bit (Z) is on the line; go to ACK.
- ACK:
  - Lines Z.
  - On the 11th falling edge, sample filtered data. 0 = ACK; 1 sets ack_err.
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until filtered clk=1 and data=1, then pulse done, go to IDLE. busy=0 in the same cycle done=1.
- Timeout:
  - Counter clears on every falling edge and on SEND entry. It counts in SEND, ACK and WAIT_IDLE.
  - At TIMEOUT_CYCLES: release both lines, set timeout_err, pulse done, go to IDLE. ack_err is left unchanged.
- write while busy=1 is ignored; the latched byte is unchanged.
- write in the same cycle as done is ignored. It is accepted in the following IDLE cycle.
- ack_err and timeout_err hold their value until the next accepted write.
- Device falling edges while in IDLE or INHIBIT are ignored; they are receiver traffic.
- Filter or counter widths must fit TIMEOUT_CYCLES with no wrap-around before the terminal count.
- reset_n low mid-transaction: lines go Z immediately (asynchronously); no done pulse.

Test Plan:
Bench overrides: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER_LEN=4; device model clocks at 40-cycle half-period.
1. write 0xF4 -> ps2_clk low for exactly 20 cycles, then start bit 0. Device samples on rising edges: 0,0,1,0,1,1,1,1, parity 0, stop 1. Device ACKs -> one done pulse, ack_err=0, timeout_err=0, both lines Z.
2. write 0xFF -> data bits all 1, parity 1. write 0x00 -> parity 1. write 0x01 -> parity 0. All complete with done and no errors.
3. Device leaves data high at ACK -> done pulse, ack_err=1, timeout_err=0. Next write 0xED clears ack_err in the acceptance cycle.
4. Device never clocks after RTS -> exactly 2000 cycles after SEND entry: timeout_err=1, done pulse, busy=0, ps2_data released.
5. write 0xF4, then write 0x00 during INHIBIT and again during SEND -> transmitted frame carries 0xF4, exactly one done pulse.
6. Assert reset_n=0 after the 4th falling edge -> ps2_clk/ps2_data Z and busy=0 before the next clk edge. After release, write 0xAA completes normally.
7. Inject 2-cycle glitches on ps2_clk in SEND -> no bit index advance; frame still correct.
